// File: rtl/ex_mem_hilo_stage_pkg.sv
// Shared definitions for the EX->MEM HI/LO stage: ALU opcodes that write HI/LO
// and the mfhi/mflo select encodings.
package ex_mem_hilo_stage_pkg;

    localparam logic [3:0] ALU_MULT   = 4'h3;
    localparam logic [3:0] ALU_DIV    = 4'h4;
    localparam logic [1:0] HILO_RD_HI = 2'b01;
    localparam logic [1:0] HILO_RD_LO = 2'b10;

    // mult and div/divu write both halves of HI/LO from the ALU pair
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV);
    endfunction

endpackage

// File: rtl/ex_mem_hilo_stage_hilo_regfile.sv
// Architectural HI/LO registers. mult/div results take precedence over
// mthi/mtlo selects; nothing is written unless wr_en is high.
module hilo_regfile
    import ex_mem_hilo_stage_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [3:0]        alu_op,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [1:0]        hilo_wr,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    logic [DATA_W-1:0] hi_r;
    logic [DATA_W-1:0] lo_r;
    logic [DATA_W-1:0] hi_nxt_s;
    logic [DATA_W-1:0] lo_nxt_s;

    // Next-value selection with write priority
    always_comb begin
        hi_nxt_s = hi_r;
        lo_nxt_s = lo_r;
        if (!wr_en) begin
            hi_nxt_s = hi_r;
            lo_nxt_s = lo_r;
        end else if (is_muldiv(alu_op)) begin
            hi_nxt_s = wdata2;
            lo_nxt_s = wdata;
        end else begin
            if (hilo_wr[1]) begin
                hi_nxt_s = wdata;
            end else begin
                hi_nxt_s = hi_r;
            end
            if (hilo_wr[0]) begin
                lo_nxt_s = wdata;
            end else begin
                lo_nxt_s = lo_r;
            end
        end
    end

    // HI/LO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {DATA_W{1'b0}};
            lo_r <= {DATA_W{1'b0}};
        end else begin
            hi_r <= hi_nxt_s;
            lo_r <= lo_nxt_s;
        end
    end

    assign hi = hi_r;
    assign lo = lo_r;

endmodule

// File: rtl/ex_mem_hilo_stage.sv
// EX->MEM pipeline register with HI/LO ownership, mfhi/mflo resolution and
// trapping-overflow squash; flush beats stall, stall freezes everything.
module ex_mem_hilo_stage
    import ex_mem_hilo_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int RADDR_W    = 5,
    parameter bit TRAP_ON_OF = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [3:0]         ex_alu_op,
    input  logic [DATA_W-1:0]  ex_result,
    input  logic [DATA_W-1:0]  ex_result2,
    input  logic               ex_of,
    input  logic               ex_trap_of,
    input  logic [1:0]         ex_hilo_rd,
    input  logic [1:0]         ex_hilo_wr,
    input  logic               ex_reg_we,
    input  logic [RADDR_W-1:0] ex_rd,
    input  logic               ex_mem_we,
    input  logic [DATA_W-1:0]  ex_store_data,
    input  logic [DATA_W-1:0]  ex_pc,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_result,
    output logic               mem_reg_we,
    output logic [RADDR_W-1:0] mem_rd,
    output logic               mem_mem_we,
    output logic [DATA_W-1:0]  mem_store_data,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo,
    output logic               exc_ov,
    output logic [DATA_W-1:0]  exc_pc
);

    logic               adv_s;
    logic               trap_s;
    logic               clear_s;
    logic [DATA_W-1:0]  fwd_result_s;
    logic [DATA_W-1:0]  hi_s;
    logic [DATA_W-1:0]  lo_s;

    logic               valid_r;
    logic [DATA_W-1:0]  result_r;
    logic               reg_we_r;
    logic [RADDR_W-1:0] rd_r;
    logic               mem_we_r;
    logic [DATA_W-1:0]  store_data_r;
    logic               exc_ov_r;
    logic [DATA_W-1:0]  exc_pc_r;

    assign adv_s   = ex_valid & ~stall & ~flush;
    assign trap_s  = TRAP_ON_OF & ex_trap_of & ex_of;
    assign clear_s = flush | (~ex_valid & ~stall);

    // mfhi/mflo read the committed HI/LO; a writer one ahead has already landed
    always_comb begin
        fwd_result_s = ex_result;
        case (ex_hilo_rd)
            HILO_RD_HI: fwd_result_s = hi_s;
            HILO_RD_LO: fwd_result_s = lo_s;
            default:    fwd_result_s = ex_result;
        endcase
    end

    hilo_regfile #(
        .DATA_W (DATA_W)
    ) u_hilo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (adv_s & ~trap_s),
        .alu_op  (ex_alu_op),
        .wdata   (ex_result),
        .wdata2  (ex_result2),
        .hilo_wr (ex_hilo_wr),
        .hi      (hi_s),
        .lo      (lo_s)
    );

    // EX->MEM pipeline register; data fields simply hold on bubble/flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r      <= 1'b0;
            result_r     <= {DATA_W{1'b0}};
            reg_we_r     <= 1'b0;
            rd_r         <= {RADDR_W{1'b0}};
            mem_we_r     <= 1'b0;
            store_data_r <= {DATA_W{1'b0}};
            exc_ov_r     <= 1'b0;
            exc_pc_r     <= {DATA_W{1'b0}};
        end else if (clear_s) begin
            valid_r  <= 1'b0;
            reg_we_r <= 1'b0;
            mem_we_r <= 1'b0;
            exc_ov_r <= 1'b0;
        end else if (adv_s) begin
            valid_r      <= 1'b1;
            result_r     <= fwd_result_s;
            reg_we_r     <= ex_reg_we & ~trap_s;
            rd_r         <= ex_rd;
            mem_we_r     <= ex_mem_we & ~trap_s;
            store_data_r <= ex_store_data;
            exc_ov_r     <= trap_s;
            if (trap_s) begin
                exc_pc_r <= ex_pc;
            end
        end
    end

    assign mem_valid      = valid_r;
    assign mem_result     = result_r;
    assign mem_reg_we     = reg_we_r;
    assign mem_rd         = rd_r;
    assign mem_mem_we     = mem_we_r;
    assign mem_store_data = store_data_r;
    assign hi             = hi_s;
    assign lo             = lo_s;
    assign exc_ov         = exc_ov_r;
    assign exc_pc         = exc_pc_r;

endmodule

// File: tb/tb_ex_mem_hilo_stage.sv
// Bench for ex_mem_hilo_stage: directed vector table, stall/flush/reset
// sequences, and random traffic against a rule-level reference model.
module tb_ex_mem_hilo_stage;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [31:0] r;
        logic [31:0] r2;
        logic        of;
        logic        tof;
        logic [1:0]  hrd;
        logic [1:0]  hwr;
        logic        rwe;
        logic [4:0]  rd;
        logic        mwe;
        logic [31:0] sd;
        logic [31:0] pc;
    } in_t;

    typedef struct packed {
        in_t         i;
        logic        e_v;
        logic [31:0] e_res;
        logic        e_rwe;
        logic        e_mwe;
        logic [31:0] e_hi;
        logic [31:0] e_lo;
        logic        e_exc;
        logic [31:0] e_epc;
        logic        e_rwe0;
        logic        e_exc0;
    } vec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] res;
        logic        rwe;
        logic [4:0]  rd;
        logic        mwe;
        logic [31:0] sd;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        exc;
        logic [31:0] epc;
    } mst_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    in_t         cur;

    logic        d0_v, d1_v, d0_rwe, d1_rwe, d0_mwe, d1_mwe, d0_exc, d1_exc;
    logic [31:0] d0_res, d1_res, d0_sd, d1_sd, d0_hi, d1_hi, d0_lo, d1_lo, d0_epc, d1_epc;
    logic [4:0]  d0_rd, d1_rd;

    int   n_pass = 0;
    int   n_tot  = 0;
    mst_t mdl0, mdl1;
    vec_t vecs[12];

    always #5 clk = ~clk;

    ex_mem_hilo_stage #(.DATA_W(32), .RADDR_W(5), .TRAP_ON_OF(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(cur.v), .ex_alu_op(cur.op), .ex_result(cur.r), .ex_result2(cur.r2),
        .ex_of(cur.of), .ex_trap_of(cur.tof), .ex_hilo_rd(cur.hrd), .ex_hilo_wr(cur.hwr),
        .ex_reg_we(cur.rwe), .ex_rd(cur.rd), .ex_mem_we(cur.mwe), .ex_store_data(cur.sd),
        .ex_pc(cur.pc), .mem_valid(d0_v), .mem_result(d0_res), .mem_reg_we(d0_rwe),
        .mem_rd(d0_rd), .mem_mem_we(d0_mwe), .mem_store_data(d0_sd), .hi(d0_hi), .lo(d0_lo),
        .exc_ov(d0_exc), .exc_pc(d0_epc));

    ex_mem_hilo_stage #(.DATA_W(32), .RADDR_W(5), .TRAP_ON_OF(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(cur.v), .ex_alu_op(cur.op), .ex_result(cur.r), .ex_result2(cur.r2),
        .ex_of(cur.of), .ex_trap_of(cur.tof), .ex_hilo_rd(cur.hrd), .ex_hilo_wr(cur.hwr),
        .ex_reg_we(cur.rwe), .ex_rd(cur.rd), .ex_mem_we(cur.mwe), .ex_store_data(cur.sd),
        .ex_pc(cur.pc), .mem_valid(d1_v), .mem_result(d1_res), .mem_reg_we(d1_rwe),
        .mem_rd(d1_rd), .mem_mem_we(d1_mwe), .mem_store_data(d1_sd), .hi(d1_hi), .lo(d1_lo),
        .exc_ov(d1_exc), .exc_pc(d1_epc));

    function automatic in_t mk(input logic v, input logic [3:0] op, input logic [31:0] r,
                               input logic [31:0] r2, input logic of, input logic tof,
                               input logic [1:0] hrd, input logic [1:0] hwr, input logic rwe,
                               input logic [4:0] rd, input logic mwe, input logic [31:0] sd,
                               input logic [31:0] pc);
        return '{v:v, op:op, r:r, r2:r2, of:of, tof:tof, hrd:hrd, hwr:hwr,
                 rwe:rwe, rd:rd, mwe:mwe, sd:sd, pc:pc};
    endfunction

    // Reference: one clock edge of the stage, stated as the architectural rules
    function automatic mst_t step(input mst_t s, input in_t i, input logic st,
                                  input logic fl, input bit trap_en);
        mst_t n = s;
        logic trap;
        if (fl || (!st && !i.v)) begin
            n.v = 1'b0; n.rwe = 1'b0; n.mwe = 1'b0; n.exc = 1'b0;
        end else if (!st) begin
            trap  = trap_en && i.tof && i.of;
            n.v   = 1'b1;
            n.res = (i.hrd == 2'b01) ? s.hi : (i.hrd == 2'b10) ? s.lo : i.r;
            n.rwe = i.rwe && !trap;
            n.mwe = i.mwe && !trap;
            n.rd  = i.rd;
            n.sd  = i.sd;
            n.exc = trap;
            if (trap) n.epc = i.pc;
            else if (i.op == 4'd3 || i.op == 4'd4) begin
                n.hi = i.r2; n.lo = i.r;
            end else begin
                if (i.hwr[1]) n.hi = i.r;
                if (i.hwr[0]) n.lo = i.r;
            end
        end
        return n;
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endfunction

    task automatic check_dut(input string tag, input mst_t m, input logic v, input logic [31:0] res,
                             input logic rwe, input logic [4:0] rd, input logic mwe,
                             input logic [31:0] sd, input logic [31:0] h, input logic [31:0] l,
                             input logic exc, input logic [31:0] epc);
        chk({tag, "_valid"}, {31'd0, v}, {31'd0, m.v});
        chk({tag, "_reg_we"}, {31'd0, rwe}, {31'd0, m.rwe});
        chk({tag, "_mem_we"}, {31'd0, mwe}, {31'd0, m.mwe});
        chk({tag, "_exc_ov"}, {31'd0, exc}, {31'd0, m.exc});
        chk({tag, "_hi"}, h, m.hi);
        chk({tag, "_lo"}, l, m.lo);
        if (m.v) begin
            chk({tag, "_result"}, res, m.res);
            chk({tag, "_rd"}, {27'd0, rd}, {27'd0, m.rd});
            chk({tag, "_store_data"}, sd, m.sd);
        end
        if (m.exc) chk({tag, "_exc_pc"}, epc, m.epc);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        mdl0 = step(mdl0, cur, stall, flush, 1'b0);
        mdl1 = step(mdl1, cur, stall, flush, 1'b1);
        @(negedge clk);
        check_dut({tag, "_t0"}, mdl0, d0_v, d0_res, d0_rwe, d0_rd, d0_mwe, d0_sd, d0_hi, d0_lo, d0_exc, d0_epc);
        check_dut({tag, "_t1"}, mdl1, d1_v, d1_res, d1_rwe, d1_rd, d1_mwe, d1_sd, d1_hi, d1_lo, d1_exc, d1_epc);
    endtask

    initial begin
        mdl0 = '0;
        mdl1 = '0;
        cur  = '0;
        vecs[0]  = '{mk(1,3,32'hFFFF_FFFE,32'h1,0,0,2'b00,2'b00,0,5'd0,0,32'h0,32'h0040_0000),
                     1, 32'hFFFF_FFFE, 0, 0, 32'h1, 32'hFFFF_FFFE, 0, 32'h0, 0, 0};
        vecs[1]  = '{mk(1,0,32'hDEAD_BEEF,32'h0,0,0,2'b01,2'b00,1,5'd5,0,32'h0,32'h0040_0004),
                     1, 32'h1, 1, 0, 32'h1, 32'hFFFF_FFFE, 0, 32'h0, 1, 0};
        vecs[2]  = '{mk(1,0,32'hDEAD_BEEF,32'h0,0,0,2'b10,2'b00,1,5'd6,0,32'h0,32'h0040_0008),
                     1, 32'hFFFF_FFFE, 1, 0, 32'h1, 32'hFFFF_FFFE, 0, 32'h0, 1, 0};
        vecs[3]  = '{mk(1,0,32'h1234_5678,32'h0,0,0,2'b11,2'b00,1,5'd7,0,32'h0,32'h0040_000C),
                     1, 32'h1234_5678, 1, 0, 32'h1, 32'hFFFF_FFFE, 0, 32'h0, 1, 0};
        vecs[4]  = '{mk(1,0,32'h8000_0000,32'h0,1,1,2'b00,2'b00,1,5'd7,0,32'h0,32'h0040_0010),
                     1, 32'h8000_0000, 0, 0, 32'h1, 32'hFFFF_FFFE, 1, 32'h0040_0010, 1, 0};
        vecs[5]  = '{mk(1,0,32'h7FFF_FFFF,32'h0,1,0,2'b00,2'b00,1,5'd8,0,32'h0,32'h0040_0014),
                     1, 32'h7FFF_FFFF, 1, 0, 32'h1, 32'hFFFF_FFFE, 0, 32'h0, 1, 0};
        vecs[6]  = '{mk(1,0,32'hAAAA_AAAA,32'h0,0,0,2'b00,2'b10,0,5'd0,0,32'h0,32'h0040_0018),
                     1, 32'hAAAA_AAAA, 0, 0, 32'hAAAA_AAAA, 32'hFFFF_FFFE, 0, 32'h0, 0, 0};
        vecs[7]  = '{mk(1,0,32'h5555_5555,32'h0,0,0,2'b00,2'b01,0,5'd0,0,32'h0,32'h0040_001C),
                     1, 32'h5555_5555, 0, 0, 32'hAAAA_AAAA, 32'h5555_5555, 0, 32'h0, 0, 0};
        vecs[8]  = '{mk(1,4,32'h7,32'h3,0,0,2'b00,2'b11,0,5'd0,0,32'h0,32'h0040_0020),
                     1, 32'h7, 0, 0, 32'h3, 32'h7, 0, 32'h0, 0, 0};
        vecs[9]  = '{mk(1,0,32'h1000,32'h0,0,0,2'b00,2'b00,0,5'd0,1,32'hCAFE_F00D,32'h0040_0024),
                     1, 32'h1000, 0, 1, 32'h3, 32'h7, 0, 32'h0, 0, 0};
        vecs[10] = '{mk(1,0,32'h5,32'h0,1,1,2'b00,2'b11,1,5'd9,1,32'h0,32'h0040_0028),
                     1, 32'h5, 0, 0, 32'h3, 32'h7, 1, 32'h0040_0028, 1, 0};
        vecs[11] = '{mk(0,0,32'h9,32'h0,0,0,2'b00,2'b11,1,5'd9,1,32'h0,32'h0040_002C),
                     0, 32'h0, 0, 0, 32'h3, 32'h7, 0, 32'h0, 0, 0};

        @(negedge clk);
        chk("reset_valid", {31'd0, d1_v}, 32'h0);
        chk("reset_hi", d1_hi, 32'h0);
        chk("reset_lo", d1_lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int k = 0; k < 12; k++) begin
            cur = vecs[k].i;
            tick($sformatf("vec%0d", k));
            chk($sformatf("vec%0d_valid", k), {31'd0, d1_v}, {31'd0, vecs[k].e_v});
            if (vecs[k].e_v) chk($sformatf("vec%0d_result", k), d1_res, vecs[k].e_res);
            chk($sformatf("vec%0d_reg_we", k), {31'd0, d1_rwe}, {31'd0, vecs[k].e_rwe});
            chk($sformatf("vec%0d_mem_we", k), {31'd0, d1_mwe}, {31'd0, vecs[k].e_mwe});
            chk($sformatf("vec%0d_hi", k), d1_hi, vecs[k].e_hi);
            chk($sformatf("vec%0d_lo", k), d1_lo, vecs[k].e_lo);
            chk($sformatf("vec%0d_exc_ov", k), {31'd0, d1_exc}, {31'd0, vecs[k].e_exc});
            if (vecs[k].e_exc) chk($sformatf("vec%0d_exc_pc", k), d1_epc, vecs[k].e_epc);
            chk($sformatf("vec%0d_reg_we_notrap", k), {31'd0, d0_rwe}, {31'd0, vecs[k].e_rwe0});
            chk($sformatf("vec%0d_exc_ov_notrap", k), {31'd0, d0_exc}, {31'd0, vecs[k].e_exc0});
        end

        // Stall for three cycles with changing EX inputs
        cur = mk(1,0,32'h1111_1111,32'h0,0,0,2'b00,2'b10,1,5'd1,0,32'h0,32'h0040_0100);
        tick("stall_pre");
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur = mk(1,3,$urandom,$urandom,1,1,2'b01,2'b11,1,5'd2,1,$urandom,$urandom);
            tick("stall");
            chk("stall_result_frozen", d1_res, 32'h1111_1111);
            chk("stall_hi_frozen", d1_hi, 32'h1111_1111);
            chk("stall_rd_frozen", {27'd0, d1_rd}, 32'd1);
        end
        stall = 1'b0;
        cur = mk(1,0,32'h2222_2222,32'h0,0,0,2'b01,2'b01,1,5'd3,0,32'h0,32'h0040_0104);
        tick("stall_release");
        chk("release_result", d1_res, 32'h1111_1111);
        chk("release_lo", d1_lo, 32'h2222_2222);
        chk("release_rd", {27'd0, d1_rd}, 32'd3);

        // Flush wins over stall with a div in EX
        stall = 1'b1;
        flush = 1'b1;
        cur = mk(1,4,32'h99,32'h88,0,0,2'b00,2'b11,1,5'd4,0,32'h0,32'h0040_0108);
        tick("flush_stall");
        chk("flush_valid", {31'd0, d1_v}, 32'h0);
        chk("flush_hi", d1_hi, 32'h1111_1111);
        chk("flush_lo", d1_lo, 32'h2222_2222);
        stall = 1'b0;
        flush = 1'b0;

        // Random traffic against the model
        for (int k = 0; k < 400; k++) begin
            cur = mk($urandom_range(0, 7) != 0, 4'($urandom_range(0, 5)), $urandom, $urandom,
                     1'($urandom), $urandom_range(0, 3) == 0, 2'($urandom), 2'($urandom),
                     1'($urandom), 5'($urandom), 1'($urandom), $urandom, $urandom);
            stall = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick("rand");
        end
        stall = 1'b0;
        flush = 1'b0;

        // Asynchronous reset mid-stream, checked between clock edges
        cur = mk(1,3,32'hFFFF_0000,32'h0000_FFFF,0,0,2'b00,2'b00,1,5'd31,1,32'h1234,32'h0040_0200);
        tick("pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, d1_v}, 32'h0);
        chk("async_rst_result", d1_res, 32'h0);
        chk("async_rst_reg_we", {31'd0, d1_rwe}, 32'h0);
        chk("async_rst_mem_we", {31'd0, d1_mwe}, 32'h0);
        chk("async_rst_rd", {27'd0, d1_rd}, 32'h0);
        chk("async_rst_store_data", d1_sd, 32'h0);
        chk("async_rst_hi", d1_hi, 32'h0);
        chk("async_rst_lo", d1_lo, 32'h0);
        chk("async_rst_exc_ov", {31'd0, d1_exc}, 32'h0);
        chk("async_rst_exc_pc", d1_epc, 32'h0);
        mdl0 = '0;
        mdl1 = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cur = mk(1,0,32'h0BAD_CAFE,32'h0,0,0,2'b10,2'b00,1,5'd12,0,32'h0,32'h0040_0300);
        tick("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
